reu_dma_seq: RTL and testbench
==============================

# reu_dma_seq

DMA transfer sequencer for the REU CPLD: the engine that executes what the REU register file has been programmed with. It waits for Execute (optionally gated by a CPU write to $FF00), takes the C64 bus via nDMA, and moves one byte per PHI2 cycle between C64 and REU RAM for stash, fetch, swap and verify. It sends NextCA, NextREUA, XferEnd and VerifyErr back to the register file, which owns all address and length counters.

## Interface
- No parameters.
- PHI2  in  1  system clock; all state updates on negedge PHI2, the same edge the register file uses.
- nReset  in  1  asynchronous, active-low reset.
- Execute  in  1  command bit 7 from the register file.
- FF00Decode  in  1  1 = start only after a CPU write to $FF00.
- FF00Wr  in  1  one-cycle pulse: the CPU wrote $FF00.
- XferType  in  2  00 stash (C64→REU), 01 fetch (REU→C64), 10 swap, 11 verify.
- Length1  in  1  the length counter equals 1, so the current byte is the last.
- BA  in  1  1 = bus available; 0 = VIC stealing cycles.
- CDataIn / RDataIn  in  8  C64 bus / REU RAM read data.
- CDataOut / RDataOut  out  8  C64 bus / REU RAM write data.
- CRd, CWr, RRd, RWr  out  1  bus access enables.
- nDMA  out  1  C64 DMA request, active low.
- NextCA, NextREUA  out  1  increment strobes to the register file.
- XferEnd  out  1  normal completion strobe.
- VerifyErr  out  1  verify mismatch strobe.
- Busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ARM, REQ, XFER, SWAPWR.
- IDLE:
  - Execute=1 and FF00Decode=0 → REQ.
  - Execute=1 and FF00Decode=1 → ARM.
  - XferType is latched into XT on the leave-IDLE edge. Later register writes have no effect until the next transfer.
- ARM:
  - FF00Wr=1 → REQ.
  - Execute=0 → IDLE. Execute=0 wins if it coincides with FF00Wr.
- REQ: nDMA asserted, no bus access; → XFER on the next edge unconditionally.
- Any transfer state (XFER, SWAPWR) with BA=0: hold state; all of CRd/CWr/RRd/RWr and all strobes are 0; nDMA stays 0.
- XFER, BA=1, bus enables and data by XT:
  - stash: CRd, RWr; RDataOut=CDataIn.
  - fetch: RRd, CWr; CDataOut=RDataIn.
  - verify: CRd, RRd; compare CDataIn with RDataIn.
  - swap: CRd, RRd; HoldC←CDataIn, HoldR←RDataIn; → SWAPWR.
- SWAPWR, BA=1: CWr, RWr; CDataOut=HoldR, RDataOut=HoldC.
- Byte completion: XFER for stash/fetch/verify, or SWAPWR for swap, with BA=1.
  - NextCA=NextREUA=1.
  - If Length1=1, XferEnd=1 as well and the next state is IDLE; otherwise XFER.
- Verify mismatch: VerifyErr=1; NextCA, NextREUA and XferEnd are all 0, even if Length1=1; → IDLE.
- Strobes and bus enables are combinational from state, XT, BA and Length1 (plus the compare result for VerifyErr). The register file therefore acts on them at the same negedge on which this block changes state.
- The register file clears Execute on XferEnd/VerifyErr at that same edge, so IDLE does not retrigger.
- Data outputs are 8'h00 when not driving a write.

## Timing
- Reset (async, nReset=0):
  - State=IDLE, XT=00, HoldC=HoldR=8'h00.
  - nDMA=1, Busy=0.
  - All enables and strobes 0, data outputs 8'h00.
  - Reset mid-transfer aborts immediately and issues no XferEnd.
- nDMA and Busy are registered: nDMA=0 exactly in REQ, XFER and SWAPWR; it returns to 1 on the edge entering IDLE.
- Latency from the Execute edge (no FF00): 1 cycle IDLE→REQ, 1 cycle REQ, first byte access in the following cycle.
- Throughput with BA=1: stash/fetch/verify 1 byte per cycle; swap 2 cycles per byte.
- Length1=1 on the first byte: single-byte transfer, XferEnd on the first completion.
- Reload and priority of XferEnd over NextCA are handled by the register file; this block always asserts NextCA/NextREUA on a completed byte.

## Test plan
- Stash, length 3, BA=1, FF00Decode=0:
  - nDMA falls 1 cycle after Execute.
  - 3 XFER cycles with CRd+RWr; RDataOut tracks CDataIn (11,22,33).
  - NextCA/NextREUA in each cycle; XferEnd with the third; nDMA=1 on the next edge.
- Fetch with FF00Decode=1:
  - Stays in ARM (Busy=1, nDMA=1) for 10 cycles.
  - FF00Wr pulse → REQ → CWr cycles with CDataOut=RDataIn.
- Swap, length 2, with BA=0 for 3 cycles mid-SWAPWR:
  - C=AA/BB and R=55/66 end up exchanged.
  - No enables or strobes during the stall; 4 active cycles plus 3 stalled.
- Verify, length 4, mismatch on byte 2 (C=12, R=13):
  - Byte 1 gives NextCA.
  - Byte 2 gives VerifyErr=1 with NextCA=0 and XferEnd=0, then IDLE.
- Execute cleared while in ARM → IDLE with no DMA; Execute cleared together with FF00Wr → IDLE.
- nReset pulsed low during XFER of a fetch:
  - nDMA=1, CWr=0 immediately.
  - After release, stays in IDLE while Execute=0.

Source files
------------

// File: rtl/reu_dma_seq.sv
// REU DMA transfer sequencer.
// Runs one programmed transfer: waits for Execute (optionally until a CPU
// write to $FF00), requests the C64 bus with nDMA, then moves one byte per
// PHI2 cycle between C64 and REU RAM (stash, fetch, swap or verify). All
// address and length counting lives in the register file; this block only
// issues the increment, end and verify-error strobes back to it.
// State advances on the falling edge of PHI2, the same edge the register
// file uses, so the combinational strobes are consumed on the edge that
// moves this sequencer on.

module reu_dma_seq (
  input  logic       PHI2,
  input  logic       nReset,
  input  logic       Execute,
  input  logic       FF00Decode,
  input  logic       FF00Wr,
  input  logic [1:0] XferType,
  input  logic       Length1,
  input  logic       BA,
  input  logic [7:0] CDataIn,
  input  logic [7:0] RDataIn,
  output logic [7:0] CDataOut,
  output logic [7:0] RDataOut,
  output logic       CRd,
  output logic       CWr,
  output logic       RRd,
  output logic       RWr,
  output logic       nDMA,
  output logic       NextCA,
  output logic       NextREUA,
  output logic       XferEnd,
  output logic       VerifyErr,
  output logic       Busy
);

  // Transfer type encodings as programmed in the command register.
  localparam logic [1:0] XT_STASH  = 2'b00;
  localparam logic [1:0] XT_FETCH  = 2'b01;
  localparam logic [1:0] XT_SWAP   = 2'b10;
  localparam logic [1:0] XT_VERIFY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    REQ    = 3'd2,
    XFER   = 3'd3,
    SWAPWR = 3'd4
  } stateT;

  stateT      stateR;
  stateT      nextStateS;
  logic [1:0] xtR;
  logic [7:0] holdCR;
  logic [7:0] holdRR;
  logic       byteDoneS;
  logic       captureHoldS;

  // Verify compare between the C64 byte and the REU byte.
  function automatic logic bytesMatch(input logic [7:0] cByte, input logic [7:0] rByte);
    bytesMatch = (cByte == rByte);
  endfunction

  // True for every state in which the C64 bus is held via nDMA.
  function automatic logic ownsBus(input stateT st);
    ownsBus = (st == REQ) || (st == XFER) || (st == SWAPWR);
  endfunction

  // Next-state decode plus combinational bus enables, data routing and strobes.
  always_comb begin
    nextStateS   = stateR;
    CRd          = 1'b0;
    CWr          = 1'b0;
    RRd          = 1'b0;
    RWr          = 1'b0;
    CDataOut     = 8'h00;
    RDataOut     = 8'h00;
    NextCA       = 1'b0;
    NextREUA     = 1'b0;
    XferEnd      = 1'b0;
    VerifyErr    = 1'b0;
    byteDoneS    = 1'b0;
    captureHoldS = 1'b0;

    case (stateR)
      IDLE: begin
        if (Execute) begin
          if (FF00Decode) begin
            nextStateS = ARM;
          end else begin
            nextStateS = REQ;
          end
        end else begin
          nextStateS = IDLE;
        end
      end

      ARM: begin
        // Dropping Execute cancels the armed transfer, even on the $FF00 write cycle.
        if (!Execute) begin
          nextStateS = IDLE;
        end else if (FF00Wr) begin
          nextStateS = REQ;
        end else begin
          nextStateS = ARM;
        end
      end

      REQ: begin
        // One cycle with nDMA low and no access, so the CPU has released the bus.
        nextStateS = XFER;
      end

      XFER: begin
        if (BA) begin
          case (xtR)
            XT_STASH: begin
              CRd       = 1'b1;
              RWr       = 1'b1;
              RDataOut  = CDataIn;
              byteDoneS = 1'b1;
            end
            XT_FETCH: begin
              RRd       = 1'b1;
              CWr       = 1'b1;
              CDataOut  = RDataIn;
              byteDoneS = 1'b1;
            end
            XT_SWAP: begin
              // Read both sides now, write them crossed over in SWAPWR.
              CRd          = 1'b1;
              RRd          = 1'b1;
              captureHoldS = 1'b1;
              nextStateS   = SWAPWR;
            end
            XT_VERIFY: begin
              CRd = 1'b1;
              RRd = 1'b1;
              if (bytesMatch(CDataIn, RDataIn)) begin
                byteDoneS = 1'b1;
              end else begin
                // A mismatch stops the transfer without advancing addresses.
                VerifyErr  = 1'b1;
                nextStateS = IDLE;
              end
            end
            default: begin
              nextStateS = IDLE;
            end
          endcase
        end else begin
          // VIC owns this cycle: hold everything, keep nDMA asserted.
          nextStateS = XFER;
        end
      end

      SWAPWR: begin
        if (BA) begin
          CWr       = 1'b1;
          RWr       = 1'b1;
          CDataOut  = holdRR;
          RDataOut  = holdCR;
          byteDoneS = 1'b1;
        end else begin
          nextStateS = SWAPWR;
        end
      end

      default: begin
        nextStateS = IDLE;
      end
    endcase

    // A completed byte always advances both address counters; the last byte also ends.
    if (byteDoneS) begin
      NextCA   = 1'b1;
      NextREUA = 1'b1;
      if (Length1) begin
        XferEnd    = 1'b1;
        nextStateS = IDLE;
      end else begin
        nextStateS = XFER;
      end
    end else begin
      NextCA   = 1'b0;
      NextREUA = 1'b0;
    end
  end

  // Sequencer state, latched transfer type, swap holding bytes and registered nDMA/Busy.
  always_ff @(negedge PHI2 or negedge nReset) begin
    if (!nReset) begin
      stateR <= IDLE;
      xtR    <= 2'b00;
      holdCR <= 8'h00;
      holdRR <= 8'h00;
      nDMA   <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      stateR <= nextStateS;
      nDMA   <= !ownsBus(nextStateS);
      Busy   <= (nextStateS != IDLE);

      // Freeze the transfer type when leaving IDLE; later register writes wait.
      if ((stateR == IDLE) && (nextStateS != IDLE)) begin
        xtR <= XferType;
      end else begin
        xtR <= xtR;
      end

      if (captureHoldS) begin
        holdCR <= CDataIn;
        holdRR <= RDataIn;
      end else begin
        holdCR <= holdCR;
        holdRR <= holdRR;
      end
    end
  end

endmodule

// File: tb/tb_reu_dma_seq.sv
// Directed self-checking bench for reu_dma_seq.
// Inputs change 1 time unit after the falling PHI2 edge, outputs are
// compared 1 unit later, well away from the next falling edge.

module tb_reu_dma_seq;

  logic       PHI2;
  logic       nReset;
  logic       Execute;
  logic       FF00Decode;
  logic       FF00Wr;
  logic [1:0] XferType;
  logic       Length1;
  logic       BA;
  logic [7:0] CDataIn;
  logic [7:0] RDataIn;
  logic [7:0] CDataOut;
  logic [7:0] RDataOut;
  logic       CRd;
  logic       CWr;
  logic       RRd;
  logic       RWr;
  logic       nDMA;
  logic       NextCA;
  logic       NextREUA;
  logic       XferEnd;
  logic       VerifyErr;
  logic       Busy;

  int checks;
  int errors;

  // Control-bit masks, packed as {CRd,CWr,RRd,RWr,NextCA,NextREUA,XferEnd,VerifyErr,nDMA,Busy}.
  localparam logic [9:0] EN_CRD  = 10'b10_0000_0000;
  localparam logic [9:0] EN_CWR  = 10'b01_0000_0000;
  localparam logic [9:0] EN_RRD  = 10'b00_1000_0000;
  localparam logic [9:0] EN_RWR  = 10'b00_0100_0000;
  localparam logic [9:0] ST_NEXT = 10'b00_0011_0000;
  localparam logic [9:0] ST_END  = 10'b00_0000_1000;
  localparam logic [9:0] ST_VERR = 10'b00_0000_0100;
  localparam logic [9:0] ST_NDMA = 10'b00_0000_0010;
  localparam logic [9:0] ST_BUSY = 10'b00_0000_0001;
  localparam logic [9:0] IDLE_V  = ST_NDMA;

  reu_dma_seq dut (
    .PHI2       (PHI2),
    .nReset     (nReset),
    .Execute    (Execute),
    .FF00Decode (FF00Decode),
    .FF00Wr     (FF00Wr),
    .XferType   (XferType),
    .Length1    (Length1),
    .BA         (BA),
    .CDataIn    (CDataIn),
    .RDataIn    (RDataIn),
    .CDataOut   (CDataOut),
    .RDataOut   (RDataOut),
    .CRd        (CRd),
    .CWr        (CWr),
    .RRd        (RRd),
    .RWr        (RWr),
    .nDMA       (nDMA),
    .NextCA     (NextCA),
    .NextREUA   (NextREUA),
    .XferEnd    (XferEnd),
    .VerifyErr  (VerifyErr),
    .Busy       (Busy)
  );

  // PHI2 free-running clock, 10 time units per cycle.
  initial begin
    PHI2 = 1'b1;
    forever #5 PHI2 = ~PHI2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %07h expected %07h", tag, obs, exp);
    end
  endtask

  // Compare the full output picture: control bits plus both data buses.
  task automatic expectOut(input string tag, input logic [9:0] ctl,
                           input logic [7:0] cOut, input logic [7:0] rOut);
    logic [25:0] obs;
    obs = {CRd, CWr, RRd, RWr, NextCA, NextREUA, XferEnd, VerifyErr, nDMA, Busy,
           CDataOut, RDataOut};
    check(tag, {6'd0, obs}, {6'd0, ctl, cOut, rOut});
  endtask

  task automatic tick;
    @(negedge PHI2);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    nReset     = 1'b0;
    Execute    = 1'b0;
    FF00Decode = 1'b0;
    FF00Wr     = 1'b0;
    XferType   = 2'b00;
    Length1    = 1'b0;
    BA         = 1'b1;
    CDataIn    = 8'hFF;
    RDataIn    = 8'hEE;

    // Reset state
    #7;
    expectOut("reset", IDLE_V, 8'h00, 8'h00);
    #5;
    nReset = 1'b1;
    tick();

    // Stash, length 3, no $FF00 gating
    Execute = 1'b1; XferType = 2'b00; BA = 1'b1; Length1 = 1'b0;
    settle();
    expectOut("stash_idle", IDLE_V, 8'h00, 8'h00);
    tick();
    expectOut("stash_req", ST_BUSY, 8'h00, 8'h00);
    tick();
    CDataIn = 8'h11; settle();
    expectOut("stash_b1", EN_CRD | EN_RWR | ST_NEXT | ST_BUSY, 8'h00, 8'h11);
    tick();
    // A late XferType write must not change the running transfer.
    CDataIn = 8'h22; XferType = 2'b01; settle();
    expectOut("stash_b2", EN_CRD | EN_RWR | ST_NEXT | ST_BUSY, 8'h00, 8'h22);
    tick();
    CDataIn = 8'h33; Length1 = 1'b1; Execute = 1'b0; settle();
    expectOut("stash_b3", EN_CRD | EN_RWR | ST_NEXT | ST_END | ST_BUSY, 8'h00, 8'h33);
    tick();
    Length1 = 1'b0; settle();
    expectOut("stash_done", IDLE_V, 8'h00, 8'h00);

    // Fetch, gated on a $FF00 write
    Execute = 1'b1; FF00Decode = 1'b1; XferType = 2'b01;
    tick();
    for (int i = 0; i < 10; i++) begin
      settle();
      expectOut("fetch_arm", ST_NDMA | ST_BUSY, 8'h00, 8'h00);
      tick();
    end
    FF00Wr = 1'b1;
    tick();
    FF00Wr = 1'b0; settle();
    expectOut("fetch_req", ST_BUSY, 8'h00, 8'h00);
    tick();
    RDataIn = 8'h5A; CDataIn = 8'h99; settle();
    expectOut("fetch_b1", EN_RRD | EN_CWR | ST_NEXT | ST_BUSY, 8'h5A, 8'h00);
    tick();
    RDataIn = 8'hC3; Length1 = 1'b1; Execute = 1'b0; FF00Decode = 1'b0; settle();
    expectOut("fetch_b2", EN_RRD | EN_CWR | ST_NEXT | ST_END | ST_BUSY, 8'hC3, 8'h00);
    tick();
    Length1 = 1'b0; settle();
    expectOut("fetch_done", IDLE_V, 8'h00, 8'h00);

    // Swap, length 2, three-cycle VIC stall inside SWAPWR
    Execute = 1'b1; XferType = 2'b10;
    tick();
    tick();
    CDataIn = 8'hAA; RDataIn = 8'h55; settle();
    expectOut("swap_rd1", EN_CRD | EN_RRD | ST_BUSY, 8'h00, 8'h00);
    tick();
    BA = 1'b0; CDataIn = 8'h01; RDataIn = 8'h02;
    for (int i = 0; i < 3; i++) begin
      settle();
      expectOut("swap_stall", ST_BUSY, 8'h00, 8'h00);
      tick();
    end
    BA = 1'b1; settle();
    expectOut("swap_wr1", EN_CWR | EN_RWR | ST_NEXT | ST_BUSY, 8'h55, 8'hAA);
    tick();
    CDataIn = 8'hBB; RDataIn = 8'h66; settle();
    expectOut("swap_rd2", EN_CRD | EN_RRD | ST_BUSY, 8'h00, 8'h00);
    tick();
    CDataIn = 8'h00; RDataIn = 8'h00; Length1 = 1'b1; Execute = 1'b0; settle();
    expectOut("swap_wr2", EN_CWR | EN_RWR | ST_NEXT | ST_END | ST_BUSY, 8'h66, 8'hBB);
    tick();
    Length1 = 1'b0; settle();
    expectOut("swap_done", IDLE_V, 8'h00, 8'h00);

    // Verify, length 4, mismatch on byte 2
    Execute = 1'b1; XferType = 2'b11;
    tick();
    tick();
    CDataIn = 8'h40; RDataIn = 8'h40; settle();
    expectOut("verify_b1", EN_CRD | EN_RRD | ST_NEXT | ST_BUSY, 8'h00, 8'h00);
    tick();
    CDataIn = 8'h12; RDataIn = 8'h13; Execute = 1'b0; settle();
    expectOut("verify_b2", EN_CRD | EN_RRD | ST_VERR | ST_BUSY, 8'h00, 8'h00);
    tick();
    settle();
    expectOut("verify_idle", IDLE_V, 8'h00, 8'h00);

    // Single-byte verify mismatch: error wins over XferEnd
    Execute = 1'b1;
    tick();
    tick();
    CDataIn = 8'h80; RDataIn = 8'h81; Length1 = 1'b1; Execute = 1'b0; settle();
    expectOut("verify_last", EN_CRD | EN_RRD | ST_VERR | ST_BUSY, 8'h00, 8'h00);
    tick();
    Length1 = 1'b0; settle();
    expectOut("verify_last_idle", IDLE_V, 8'h00, 8'h00);

    // Execute cleared while armed, then cleared together with FF00Wr
    Execute = 1'b1; FF00Decode = 1'b1; XferType = 2'b00;
    tick();
    settle();
    expectOut("arm_enter", ST_NDMA | ST_BUSY, 8'h00, 8'h00);
    Execute = 1'b0;
    tick();
    settle();
    expectOut("arm_abort", IDLE_V, 8'h00, 8'h00);
    Execute = 1'b1;
    tick();
    Execute = 1'b0; FF00Wr = 1'b1;
    tick();
    FF00Wr = 1'b0; settle();
    expectOut("arm_abort_ff00", IDLE_V, 8'h00, 8'h00);
    tick();
    settle();
    expectOut("arm_abort_stay", IDLE_V, 8'h00, 8'h00);

    // Reset pulsed during a fetch byte
    Execute = 1'b1; FF00Decode = 1'b0; XferType = 2'b01; RDataIn = 8'h3C;
    tick();
    tick();
    settle();
    expectOut("rst_pre", EN_RRD | EN_CWR | ST_NEXT | ST_BUSY, 8'h3C, 8'h00);
    nReset = 1'b0;
    settle();
    expectOut("rst_abort", IDLE_V, 8'h00, 8'h00);
    Execute = 1'b0;
    nReset  = 1'b1;
    tick();
    settle();
    expectOut("rst_stay1", IDLE_V, 8'h00, 8'h00);
    tick();
    settle();
    expectOut("rst_stay2", IDLE_V, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
